// File: rtl/act_pkg.sv
// act_pkg: shared config addresses and sink state encoding for the activation stage.
package act_pkg;
  localparam logic [5:0] ACT_CFG_MODE    = 6'h30;
  localparam logic [5:0] ACT_CFG_WB_BASE = 6'h34;
  localparam logic [5:0] ACT_CFG_WB_LEN  = 6'h35;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} sink_state_e;
endpackage

// File: rtl/act_sync_fifo.sv
// act_sync_fifo: single-clock FIFO whose head is read straight from storage flops.
module act_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/act_wb_sink.sv
// act_wb_sink: buffers activation beats and writes them to the scratchpad from a base address,
// checking the beat count against the programmed length.
module act_wb_sink
  import act_pkg::*;
#(
  parameter int AXI_WIDTH  = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cfg_wr_en,
  input  logic [5:0]            cfg_addr,
  input  logic [63:0]           cfg_wdata,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AXI_WIDTH-1:0]  in_data,
  input  logic                  in_last,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [AXI_WIDTH-1:0]  mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  sink_state_e state;
  logic [ADDR_WIDTH-1:0] cfg_base, work_base, wr_idx;
  logic [15:0] cfg_len, work_len, beat_cnt;
  logic [16:0] cnt_next;
  logic fifo_full, fifo_empty, accept, wr;
  logic unused_cfg;
  assign unused_cfg = ^cfg_wdata;
  assign accept   = in_valid && in_ready;
  assign wr       = mem_req && mem_gnt;
  assign cnt_next = {1'b0, beat_cnt} + 17'd1;
  assign in_ready = (state == RUN) && !fifo_full;
  assign mem_req  = !fifo_empty;
  assign mem_addr = work_base + wr_idx;
  assign busy     = state != IDLE;
  assign done     = state == FIN;
  act_sync_fifo #(.WIDTH(AXI_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (wr),
    .wdata (in_data),
    .head  (mem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg_base  <= '0;
      cfg_len   <= '0;
      work_base <= '0;
      work_len  <= '0;
      wr_idx    <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      if (cfg_wr_en && cfg_addr == ACT_CFG_WB_BASE) cfg_base <= cfg_wdata[ADDR_WIDTH-1:0];
      if (cfg_wr_en && cfg_addr == ACT_CFG_WB_LEN) cfg_len <= cfg_wdata[15:0];
      if (wr) wr_idx <= wr_idx + ADDR_WIDTH'(1);
      case (state)
        IDLE: if (start) begin
          work_base <= cfg_base;
          work_len  <= cfg_len;
          wr_idx    <= '0;
          beat_cnt  <= '0;
          err       <= 1'b0;
          state     <= (cfg_len == '0) ? FIN : RUN;
        end
        RUN: if (accept) begin
          beat_cnt <= cnt_next[15:0];
          // last exactly at len is clean; early last or count hit without last is a framing error
          if (in_last || cnt_next == {1'b0, work_len}) begin
            state <= DRAIN;
            err   <= in_last ? (cnt_next < {1'b0, work_len}) : 1'b1;
          end
        end
        DRAIN: if (fifo_empty) state <= FIN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_act_wb_sink.sv
// tb_act_wb_sink: directed scenario tests for the activation write-back sink.
module tb_act_wb_sink;
  logic clk = 0, rst = 1, start = 0, cfg_wr_en = 0;
  logic [5:0] cfg_addr = '0;
  logic [63:0] cfg_wdata = '0;
  logic in_valid = 0, in_last = 0, mem_gnt = 0;
  logic [127:0] in_data = '0;
  logic in_ready, mem_req, busy, done, err;
  logic [15:0] mem_addr;
  logic [127:0] mem_wdata;
  int checks = 0, errors = 0;
  int nw, accepted, ndone, done_cyc, ready_drop, stall_bad, any_req, wcyc[16];
  logic err_done, busy0, ready0;
  logic [15:0] wa[16];
  logic [127:0] wd[16];

  act_wb_sink dut (
    .clk(clk), .rst(rst), .start(start), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] beat(input logic [15:0] base, input int i);
    return {32'hDA7A0000 + i, 32'h11111111 * i, 16'h0, base, 32'hCAFE0000 + i};
  endfunction

  task automatic cfg_write(input logic [5:0] a, input logic [63:0] d);
    @(posedge clk); #1;
    cfg_wr_en = 1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_wr_en = 0;
  endtask

  // Runs one transfer and records what the scratchpad side observed.
  task automatic do_xfer(input logic [15:0] base, input logic [15:0] len, input int nbeats,
                         input int last_at, input int gnt_mode);
    int bi, t;
    logic prev_stall, last_acc, stop;
    logic [15:0] pa;
    logic [127:0] pd;
    cfg_write(6'h34, {48'h0, base});
    cfg_write(6'h35, {48'h0, len});
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0;
    nw = 0; ndone = 0; done_cyc = -1; ready_drop = 0; stall_bad = 0; any_req = 0;
    err_done = 1'bx; bi = 0; prev_stall = 0; last_acc = 0; stop = 0; pa = '0; pd = '0;
    for (t = 0; t < 200 && !stop; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      in_valid = bi < nbeats;
      in_data  = beat(base, bi);
      in_last  = bi == last_at;
      mem_gnt  = gnt_mode == 0 ? 1'b1 :
                 (t >= 5 && ((t - 5) % 4 == 0 || (t - 5) % 4 == 3));
      #1;
      if (t == 0) begin busy0 = busy; ready0 = in_ready; end
      if (prev_stall && (mem_req !== 1'b1 || mem_addr !== pa || mem_wdata !== pd)) stall_bad++;
      prev_stall = mem_req && !mem_gnt; pa = mem_addr; pd = mem_wdata;
      if (mem_req) any_req = 1;
      if (mem_req && mem_gnt && nw < 16) begin
        wa[nw] = mem_addr; wd[nw] = mem_wdata; wcyc[nw] = t; nw++;
      end
      if (!in_ready && busy && !done && !last_acc && bi < int'(len) && bi < nbeats) ready_drop++;
      if (in_valid && in_ready) begin
        if (in_last) last_acc = 1;
        bi++;
      end
      if (done) begin
        if (ndone == 0) begin done_cyc = t; err_done = err; end
        ndone++;
      end
      if (ndone > 0 && t >= done_cyc + 3) stop = 1;
    end
    accepted = bi;
    in_valid = 0; in_last = 0; mem_gnt = 0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({in_ready, mem_req, busy, done, err} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl got %b exp 00000", {in_ready, mem_req, busy, done, err}); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 128'h0) begin errors++;
      $display("FAIL reset_mem got %h/%h exp 0/0", mem_addr, mem_wdata); end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_basic;
    do_xfer(16'h0100, 16'd4, 4, 3, 0);
    checks++; if (busy0 !== 1'b1 || ready0 !== 1'b1) begin errors++;
      $display("FAIL basic_start got busy=%b rdy=%b exp 1 1", busy0, ready0); end
    checks++; if (nw !== 4) begin errors++; $display("FAIL basic_nw got %0d exp 4", nw); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (wa[j] !== 16'h0100 + 16'(j) || wd[j] !== beat(16'h0100, j)) begin errors++;
        $display("FAIL basic_wr%0d got %h/%h exp %h/%h", j, wa[j], wd[j], 16'h0100 + 16'(j), beat(16'h0100, j)); end
      checks++; if (wcyc[j] !== 1 + j) begin errors++;
        $display("FAIL basic_cyc%0d got %0d exp %0d", j, wcyc[j], 1 + j); end
    end
    checks++; if (ndone !== 1 || err_done !== 1'b0) begin errors++;
      $display("FAIL basic_done got n=%0d err=%b exp 1 0", ndone, err_done); end
    checks++; if (done_cyc < 5) begin errors++;
      $display("FAIL basic_done_lat got %0d exp >=5", done_cyc); end
    checks++; if (ready_drop !== 0) begin errors++;
      $display("FAIL basic_ready_drop got %0d exp 0", ready_drop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", busy); end
  endtask

  task automatic test_stall;
    do_xfer(16'h0200, 16'd6, 6, 5, 1);
    checks++; if (nw !== 6) begin errors++; $display("FAIL stall_nw got %0d exp 6", nw); end
    for (int j = 0; j < 6; j++) begin
      checks++;
      if (wa[j] !== 16'h0200 + 16'(j) || wd[j] !== beat(16'h0200, j)) begin errors++;
        $display("FAIL stall_wr%0d got %h/%h exp %h/%h", j, wa[j], wd[j], 16'h0200 + 16'(j), beat(16'h0200, j)); end
    end
    checks++; if (ready_drop == 0) begin errors++;
      $display("FAIL stall_full got %0d exp >0", ready_drop); end
    checks++; if (stall_bad !== 0) begin errors++;
      $display("FAIL stall_hold got %0d exp 0", stall_bad); end
    checks++; if (ndone !== 1 || err_done !== 1'b0) begin errors++;
      $display("FAIL stall_done got n=%0d err=%b exp 1 0", ndone, err_done); end
  endtask

  task automatic test_early_last;
    do_xfer(16'h0300, 16'd4, 4, 1, 0);
    checks++; if (accepted !== 2 || nw !== 2) begin errors++;
      $display("FAIL early_cnt got acc=%0d nw=%0d exp 2 2", accepted, nw); end
    checks++; if (wa[1] !== 16'h0301 || wd[1] !== beat(16'h0300, 1)) begin errors++;
      $display("FAIL early_wr1 got %h exp 0301", wa[1]); end
    checks++; if (ndone !== 1 || err_done !== 1'b1) begin errors++;
      $display("FAIL early_done got n=%0d err=%b exp 1 1", ndone, err_done); end
    checks++; if (in_ready !== 1'b0 || err !== 1'b1) begin errors++;
      $display("FAIL early_after got rdy=%b err=%b exp 0 1", in_ready, err); end
  endtask

  task automatic test_missing_last;
    do_xfer(16'h0400, 16'd3, 5, -1, 0);
    checks++; if (accepted !== 3 || nw !== 3) begin errors++;
      $display("FAIL miss_cnt got acc=%0d nw=%0d exp 3 3", accepted, nw); end
    checks++; if (wa[2] !== 16'h0402 || wd[2] !== beat(16'h0400, 2)) begin errors++;
      $display("FAIL miss_wr2 got %h exp 0402", wa[2]); end
    checks++; if (ndone !== 1 || err_done !== 1'b1) begin errors++;
      $display("FAIL miss_done got n=%0d err=%b exp 1 1", ndone, err_done); end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    do_xfer(16'hFFFE, 16'd4, 4, 3, 0);
    checks++; if (nw !== 4) begin errors++; $display("FAIL wrap_nw got %0d exp 4", nw); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (wa[j] !== exp_a[j] || wd[j] !== beat(16'hFFFE, j)) begin errors++;
        $display("FAIL wrap_wr%0d got %h exp %h", j, wa[j], exp_a[j]); end
    end
    checks++; if (err_done !== 1'b0) begin errors++;
      $display("FAIL wrap_err_clear got %b exp 0", err_done); end
  endtask

  task automatic test_len_zero;
    do_xfer(16'h0500, 16'd0, 0, -1, 0);
    checks++; if (ndone !== 1 || done_cyc !== 0) begin errors++;
      $display("FAIL len0_done got n=%0d cyc=%0d exp 1 0", ndone, done_cyc); end
    checks++; if (any_req !== 0 || err_done !== 1'b0) begin errors++;
      $display("FAIL len0_req got req=%0d err=%b exp 0 0", any_req, err_done); end
  endtask

  task automatic test_mid_reset;
    int nd;
    cfg_write(6'h34, 64'h0600);
    cfg_write(6'h35, 64'd8);
    @(posedge clk); #1; start = 1;
    @(posedge clk); #1; start = 0; in_valid = 1; in_data = beat(16'h0600, 0); mem_gnt = 0;
    @(posedge clk); #1; in_data = beat(16'h0600, 1);
    @(posedge clk); #1; in_valid = 0;
    checks++; if (busy !== 1'b1 || mem_req !== 1'b1) begin errors++;
      $display("FAIL mrst_pre got busy=%b req=%b exp 1 1", busy, mem_req); end
    #2; rst = 1; #1;
    checks++; if ({in_ready, mem_req, busy, done, err} !== 5'b0) begin errors++;
      $display("FAIL mrst_ctrl got %b exp 00000", {in_ready, mem_req, busy, done, err}); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 128'h0) begin errors++;
      $display("FAIL mrst_mem got %h/%h exp 0/0", mem_addr, mem_wdata); end
    @(posedge clk); #1; rst = 0; mem_gnt = 1; nd = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (done || mem_req) nd++; end
    checks++; if (nd !== 0) begin errors++; $display("FAIL mrst_nodone got %0d exp 0", nd); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_early_last;
    test_missing_last;
    test_wrap;
    test_len_zero;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
